// File: rtl/uart_pkg.sv
// Shared definitions for the IO-bus UART: FSM states, IO address decode bits
// and status word layout.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // One-hot word-address select bits within IO space
  localparam int unsigned IO_LED_bit       = 0;
  localparam int unsigned IO_UART_DATA_bit = 1;
  localparam int unsigned IO_UART_STAT_bit = 2;

  localparam int unsigned STAT_BUSY_BIT = 0;
  localparam int unsigned STAT_FULL_BIT = 1;
  localparam int unsigned STAT_OVF_BIT  = 2;

  typedef struct packed {
    logic [28:0] rsvd;
    logic        overflow;
    logic        full;
    logic        busy;
  } uart_status_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; dout shows the head entry
// combinationally. A push while full is accepted when a pop lands in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push_c, do_pop_c;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout      = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop_c  = pop & ~empty;
  assign do_push_c = push & (~full | do_pop_c);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_c) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only visible through the pointers
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: IO write decode into a byte FIFO,
// baud-timed serialiser FSM, and a registered status readback word.
module io_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 12_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_sel,
  input  logic [29:0] io_wordaddr,
  input  logic        io_wstrb,
  input  logic [31:0] io_wdata,
  input  logic        io_rstrb,
  output logic [31:0] io_rdata,
  output logic        tx
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("io_uart_tx: CLK_FREQ/BAUD must be at least 4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("io_uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;
  uart_status_t     rdata_q, rdata_d;

  logic             data_wr_c, stat_rd_c, pop_c, bit_done_c, busy_c;
  logic [7:0]       fifo_dout;
  logic             fifo_full, fifo_empty;
  logic             unused_bits;

  assign data_wr_c  = io_sel & io_wstrb & io_wordaddr[IO_UART_DATA_bit];
  assign stat_rd_c  = io_sel & io_rstrb & io_wordaddr[IO_UART_STAT_bit];
  assign bit_done_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign busy_c     = ~fifo_empty | (state_q != IDLE);

  assign unused_bits = ^{io_wdata[31:8], io_wordaddr[29:3], io_wordaddr[IO_LED_bit]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_wr_c),
    .pop   (pop_c),
    .din   (io_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Serialiser: tx is registered from the current state, one cycle behind it
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop_c     = 1'b0;
    tx_d      = 1'b1;
    if (state_q != IDLE) cnt_d = bit_done_c ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = fifo_dout;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_done_c) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_done_c) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_done_c) begin
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            shift_d = fifo_dout;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky overflow (set beats clear) and status readback
  always_comb begin
    ovf_d   = ovf_q;
    rdata_d = rdata_q;
    if (stat_rd_c) ovf_d = 1'b0;
    if (data_wr_c && fifo_full && !pop_c) ovf_d = 1'b1;
    if (io_rstrb) begin
      rdata_d = '0;
      if (stat_rd_c) begin
        rdata_d.busy     = busy_c;
        rdata_d.full     = fifo_full;
        rdata_d.overflow = ovf_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
      rdata_q   <= rdata_d;
    end
  end

  assign tx       = tx_q;
  assign io_rdata = rdata_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Scoreboarded bench for io_uart_tx: accepted bytes are queued by the stimulus,
// and a line monitor decodes every frame on tx cycle by cycle against them.
module tb_io_uart_tx;

  localparam int unsigned CPB   = 10;
  localparam int unsigned DEPTH = 8;
  localparam int          FRAME = 10 * int'(CPB);

  logic        clk = 1'b0;
  logic        rst;
  logic        io_sel, io_wstrb, io_rstrb, tx;
  logic [29:0] io_wordaddr;
  logic [31:0] io_wdata, io_rdata;

  typedef struct {
    bit         b2b;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] wq[$];
  int         checks   = 0;
  int         failures = 0;

  bit         in_frame = 0, b2b_pend = 0, unexp = 0, fbad = 0;
  int         fcyc = 0;
  logic [7:0] cur, got;

  always #5 clk = ~clk;

  io_uart_tx #(
    .CLK_FREQ   (1000),
    .BAUD       (100),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .io_sel      (io_sel),
    .io_wordaddr (io_wordaddr),
    .io_wstrb    (io_wstrb),
    .io_wdata    (io_wdata),
    .io_rstrb    (io_rstrb),
    .io_rdata    (io_rdata),
    .tx          (tx)
  );

  task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", name, got_v, exp_v);
    end
  endtask

  // Line monitor, one call per falling clock edge
  task automatic mon_step();
    int   bi;
    logic lvl;
    if (rst) begin
      in_frame = 0;
      b2b_pend = 0;
      return;
    end
    if (b2b_pend) begin
      chk("b2b_no_gap", 32'(tx), 32'h0);
      b2b_pend = 0;
    end
    if (!in_frame && tx === 1'b0) begin
      in_frame = 1;
      fcyc     = 0;
      fbad     = 0;
      got      = '0;
      chk("frame_expected", 32'(sb.size() > 0), 32'h1);
      if (sb.size() > 0) begin
        cur   = sb[0].data;
        unexp = 0;
        void'(sb.pop_front());
      end else begin
        cur   = '0;
        unexp = 1;
      end
    end
    if (in_frame) begin
      bi  = fcyc / int'(CPB);
      lvl = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : cur[bi-1];
      if (tx !== lvl) fbad = 1;
      if (bi >= 1 && bi <= 8 && (fcyc % int'(CPB)) == int'(CPB) / 2) got[bi-1] = tx;
      if (fcyc == FRAME - 1) begin
        in_frame = 0;
        if (!unexp) begin
          checks++;
          if (fbad || got !== cur) begin
            failures++;
            $display("FAIL frame: got=0x%02h exp=0x%02h timing_err=%0d", got, cur, fbad);
          end
        end
        unexp    = 0;
        b2b_pend = (sb.size() > 0) && sb[0].b2b;
      end
      fcyc++;
    end
  endtask

  task automatic idle_bus();
    io_sel      = 1'b0;
    io_wstrb    = 1'b0;
    io_rstrb    = 1'b0;
    io_wordaddr = '0;
    io_wdata    = '0;
  endtask

  // Consecutive-cycle writes of wq starting from an idle transmitter: the first
  // byte leaves the FIFO one cycle after its write, so DEPTH+1 bytes fit.
  task automatic burst(input bit last_reads_stat);
    exp_t e;
    for (int i = 0; i < wq.size(); i++) begin
      @(negedge clk);
      io_sel      = 1'b1;
      io_wstrb    = 1'b1;
      io_rstrb    = 1'b0;
      io_wordaddr = 30'(2);
      io_wdata    = {24'($urandom), wq[i]};
      if (last_reads_stat && i == wq.size() - 1) begin
        io_rstrb    = 1'b1;
        io_wordaddr = 30'(6);
      end
      if (i < int'(DEPTH) + 1) begin
        e.b2b  = (i > 0);
        e.data = wq[i];
        sb.push_back(e);
      end
    end
    @(negedge clk);
    idle_bus();
  endtask

  task automatic read_reg(input logic [29:0] addr, output logic [31:0] v);
    @(negedge clk);
    io_sel      = 1'b1;
    io_rstrb    = 1'b1;
    io_wordaddr = addr;
    @(negedge clk);
    idle_bus();
    v = io_rdata;
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] v;
    int          n = 0;
    do begin
      read_reg(30'(4), v);
      n++;
    end while (v[0] && n < 2000);
    chk(name, v, 32'h0);
  endtask

  initial begin
    logic [31:0] v;
    bit          saw_low;
    int          lat, k, acc;
    logic [31:0] exp_s;

    idle_bus();
    rst = 1'b1;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'h1);
    chk("reset_rdata", io_rdata, 32'h0);
    rst = 1'b0;

    saw_low = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1;
    end
    chk("idle_tx_high", 32'(saw_low), 32'h0);
    read_reg(30'(4), v);
    chk("idle_status", v, 32'h0);

    // Single byte: start-bit latency and busy across the frame
    wq = '{8'h55};
    burst(0);
    lat = 0;
    while (tx !== 1'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("start_latency", 32'(lat), 32'd2);
    read_reg(30'(4), v);
    chk("busy_in_frame", v, 32'h1);
    repeat (100) @(negedge clk);
    read_reg(30'(4), v);
    chk("status_after_frame", v, 32'h0);

    wq = '{8'hA3, 8'h0F};
    burst(0);
    wait_idle("idle_after_pair");

    // Random bursts; first one is the 10-byte overflow case
    for (int r = 0; r < 8; r++) begin
      k = (r == 0) ? 10 : int'($urandom_range(1, 12));
      wq.delete();
      for (int i = 0; i < k; i++) wq.push_back(8'($urandom));
      burst(0);
      acc   = (k < int'(DEPTH) + 1) ? k : int'(DEPTH) + 1;
      exp_s = 32'h1;
      if (acc - 1 == int'(DEPTH)) exp_s[1] = 1'b1;
      if (k > int'(DEPTH) + 1)    exp_s[2] = 1'b1;
      read_reg(30'(4), v);
      chk("burst_status", v, exp_s);
      exp_s[2] = 1'b0;
      read_reg(30'(4), v);
      chk("burst_status_reread", v, exp_s);
      read_reg(30'(1), v);
      chk("unselected_read", v, 32'h0);
      wait_idle("idle_after_burst");
    end

    // Overflow event coinciding with a status read
    wq.delete();
    for (int i = 0; i < 10; i++) wq.push_back(8'($urandom));
    burst(1);
    chk("ovf_read_same_cycle", io_rdata, 32'h3);
    read_reg(30'(4), v);
    chk("ovf_kept", v, 32'h7);
    read_reg(30'(4), v);
    chk("ovf_cleared", v, 32'h3);
    wait_idle("idle_after_ovf");

    // Reset during the data bits of a frame with more bytes queued
    wq = '{8'h5A, 8'hC3, 8'h96};
    burst(0);
    lat = 0;
    while (tx !== 1'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    chk("rst_mid_frame_tx", 32'(tx), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    read_reg(30'(4), v);
    chk("rst_mid_frame_status", v, 32'h0);
    saw_low = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1;
    end
    chk("no_frames_after_rst", 32'(saw_low), 32'h0);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Memory-mapped UART transmitter on the SoC IO bus, next to the LED register. It consumes CPU store traffic that the top-level decodes as IO (address bit 22 set), queues bytes in a small FIFO, and serialises them 8N1 on `tx`. It also returns a status word on IO reads so firmware can poll before writing.

## Interface
- `CLK_FREQ`, default 12_000_000: clock frequency in Hz.
- `BAUD`, default 115_200: line rate; `CLKS_PER_BIT = CLK_FREQ/BAUD`, integer division, must be ≥ 4 (elaboration error otherwise).
- `FIFO_DEPTH`, default 8: power of two, ≥ 2.
- Clocking and reset (already decided): one clock, `clk`; reset `rst` is synchronous and active-high.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `io_sel`  in  1: access targets IO space, i.e. address bit 22.
- `io_wordaddr`  in  30: word address, address bits 31:2; one-hot register select.
- `io_wstrb`  in  1: write strobe, OR of the byte write mask.
- `io_wdata`  in  32: write data; only bits 7:0 are used.
- `io_rstrb`  in  1: read strobe.
- `io_rdata`  out  32: registered status readback.
- `tx`  out  1: serial line, idle high.

## Operation
- Register select: data write when `io_sel & io_wstrb & io_wordaddr[IO_UART_DATA_bit]` (bit 1). Status read when `io_sel & io_rstrb & io_wordaddr[IO_UART_STAT_bit]` (bit 2). Bit 0 is the LED register and is ignored here.
- Data write, FIFO not full: push `io_wdata[7:0]`. FIFO full: drop the byte and set sticky `overflow`.
- Write and pop in the same cycle while full: the pop frees a slot, so the write is accepted and `overflow` is not set.
- Status word: bit0 `busy` (FIFO non-empty or FSM not IDLE); bit1 `full`; bit2 `overflow`; bits 31:3 zero.
- `overflow` clears on a status read. If an overflow event and a status read land in the same cycle, the set wins.
- FSM states, each of 1..4 lasting `CLKS_PER_BIT` cycles except IDLE:
  - IDLE: `tx=1`. If FIFO non-empty, pop into the shift register and go to START.
  - START: `tx=0`, then go to DATA.
  - DATA: 8 bits, LSB first; a bit index counts 0..7, then go to STOP.
  - STOP: `tx=1`. Then go to IDLE, or straight to START with a pop if the FIFO is non-empty.
- Baud counter: counts 0..`CLKS_PER_BIT-1` and reloads on every state/bit boundary. Its width is `$clog2(CLKS_PER_BIT)`.

## Timing
- Reset values: `tx=1`, `io_rdata=0`, FIFO empty, `overflow=0`, FSM IDLE, counters 0.
- Write accepted at edge N. Pop at edge N+1. `tx` falls after edge N+2 (start bit), a 2-cycle latency from an idle state.
- Frame length: exactly `10*CLKS_PER_BIT` cycles.
- Back-to-back frames: the next start bit follows the stop bit with zero idle cycles.
- `io_rdata`: updated at the edge after `io_rstrb`, i.e. 1-cycle latency; it holds its value otherwise.
- Reads of unselected addresses: `io_rdata` loads 0.
- Reset mid-frame: `tx` is high after the reset edge, FIFO contents are lost and the partial frame is abandoned.
- FIFO pointers: log2(`FIFO_DEPTH`)+1 bits. Full when MSBs differ and the remaining bits are equal; wrap-around is natural.

## Structure
- Package `uart_pkg`:
  - state enum `uart_state_t` {IDLE, START, DATA, STOP};
  - address bit constants `IO_LED_bit=0`, `IO_UART_DATA_bit=1`, `IO_UART_STAT_bit=2`;
  - status bit positions.
- Sub-module `sync_fifo`:
  - parameterised width and depth;
  - `push`, `pop`, `din`, `dout`, `full`, `empty`;
  - `dout` combinational from the read pointer;
  - reusable for a later RX block.
- Top: decode, status register, baud counter and FSM.

## Test plan
Use `CLK_FREQ=1000` and `BAUD=100`, giving 10 clocks per bit.
- Reset, then idle for 50 cycles → `tx` stays 1 and status reads 0x0.
- Write 0x55 from idle → `tx` low for cycles 3..12 after the write, then 10-cycle bits 1,0,1,0,1,0,1,0, then high; status `busy=1` during the frame and 0x0 after 100 cycles.
- Write 0xA3 then 0x0F on consecutive cycles → two contiguous frames, 200 cycles with no idle gap; bit pattern LSB first is 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
- Write 10 bytes rapidly with depth 8 → 9 bytes transmitted (1 popped early, 8 queued), 1 dropped. Status reads 0x7, then 0x3 on the next read.
- Overflow set and status read in the same cycle → the read returns the old value and bit2 stays 1 afterwards.
- Assert `rst` midway through the DATA bits → `tx=1` next cycle, status 0x0, and no further frames are sent.
